sync_fifo_flex: RTL and testbench

Parametrised synchronous FIFO. It is the next generation of the pipeline's shift-register FIFO: a circular buffer with read and write pointers, any DEPTH of 2 or more, and a selectable first-word-fall-through (FWFT) or registered-read mode. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow flags. It is used in fetch/LSU buffering, where simultaneous push and pop at full must not stall.

---
 rtl/sync_fifo_flex.sv | 119 +++++++++++
 tb/tb_sync_fifo_flex.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Parametrised synchronous circular-buffer FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and FWFT option.
module sync_fifo_flex #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = 0,
    parameter int AF_THR     = DEPTH - 1,
    parameter int AE_THR     = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  fifo_full,
    output logic                  fifo_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  fifo_empty,
    output logic                  fifo_almost_empty,
    output logic [CW-1:0]         fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THR);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THR);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  pop_ok;
    logic                  push_ok;

    // Explicit wrap so non power-of-two depths never index past the end
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign fifo_count        = count;
    assign fifo_full         = (count == FULL_CNT);
    assign fifo_empty        = (count == '0);
    assign fifo_almost_full  = (count >= AF_CNT);
    assign fifo_almost_empty = (count <= AE_CNT);

    assign pop_ok  = rd_en & ~fifo_empty;
    assign push_ok = wr_en & (~fifo_full | pop_ok);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (fifo_clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            if (wr_en && !push_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT == 0) begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_data_valid_q;

        // Clear leaves the output word alone; only its valid drops
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_data_q       <= '0;
                rd_data_valid_q <= 1'b0;
            end else if (fifo_clear) begin
                rd_data_valid_q <= 1'b0;
            end else begin
                rd_data_valid_q <= pop_ok;
                if (pop_ok) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data       = rd_data_q;
        assign rd_data_valid = rd_data_valid_q;
    end else begin : g_fwft
        assign rd_data       = mem[rd_ptr];
        assign rd_data_valid = ~fifo_empty;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: DEPTH=4 registered-read instance and
// DEPTH=5 first-word-fall-through instance driven from one sequence.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Instance a: DEPTH=4, FWFT=0, AF_THR=3, AE_THR=1
    logic        a_rst_n, a_clr, a_we, a_re;
    logic [15:0] a_wd, a_rd;
    logic        a_full, a_af, a_valid, a_empty, a_ae, a_ovf, a_unf;
    logic [2:0]  a_cnt;

    sync_fifo_flex #(
        .DEPTH(4), .DATA_WIDTH(16), .FWFT(0), .AF_THR(3), .AE_THR(1)
    ) u_a (
        .clk(clk), .reset_n(a_rst_n), .fifo_clear(a_clr),
        .wr_en(a_we), .wr_data(a_wd), .fifo_full(a_full),
        .fifo_almost_full(a_af), .rd_en(a_re), .rd_data(a_rd),
        .rd_data_valid(a_valid), .fifo_empty(a_empty),
        .fifo_almost_empty(a_ae), .fifo_count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf)
    );

    // Instance b: DEPTH=5, FWFT=1
    logic        b_rst_n, b_clr, b_we, b_re;
    logic [15:0] b_wd, b_rd;
    logic        b_full, b_af, b_valid, b_empty, b_ae, b_ovf, b_unf;
    logic [2:0]  b_cnt;

    sync_fifo_flex #(
        .DEPTH(5), .DATA_WIDTH(16), .FWFT(1)
    ) u_b (
        .clk(clk), .reset_n(b_rst_n), .fifo_clear(b_clr),
        .wr_en(b_we), .wr_data(b_wd), .fifo_full(b_full),
        .fifo_almost_full(b_af), .rd_en(b_re), .rd_data(b_rd),
        .rd_data_valid(b_valid), .fifo_empty(b_empty),
        .fifo_almost_empty(b_ae), .fifo_count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [15:0] d);
        a_we = 1'b1; a_wd = d; a_re = 1'b0;
        tick();
        a_we = 1'b0;
    endtask

    task automatic a_pop(input logic [15:0] exp, input string tag);
        a_re = 1'b1; a_we = 1'b0;
        tick();
        a_re = 1'b0;
        chk(tag, {16'h0, a_rd}, {16'h0, exp});
        chk({tag, "_v"}, {31'h0, a_valid}, 1);
    endtask

    initial begin
        a_rst_n = 1'b0; a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0; a_wd = '0;
        b_rst_n = 1'b0; b_clr = 1'b0; b_we = 1'b0; b_re = 1'b0; b_wd = '0;
        tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Reset state
        chk("rst_empty", {31'h0, a_empty}, 1);
        chk("rst_full", {31'h0, a_full}, 0);
        chk("rst_cnt", {29'h0, a_cnt}, 0);
        chk("rst_rd", {16'h0, a_rd}, 0);
        chk("rst_valid", {31'h0, a_valid}, 0);
        chk("rst_ae", {31'h0, a_ae}, 1);
        chk("rst_af", {31'h0, a_af}, 0);
        chk("rst_b_valid", {31'h0, b_valid}, 0);

        // Fill to full, checking thresholds (AE<=1, AF>=3)
        a_push(16'hA1);
        chk("f1_cnt", {29'h0, a_cnt}, 1);
        chk("f1_ae", {31'h0, a_ae}, 1);
        chk("f1_af", {31'h0, a_af}, 0);
        a_push(16'hA2);
        chk("f2_cnt", {29'h0, a_cnt}, 2);
        chk("f2_ae", {31'h0, a_ae}, 0);
        chk("f2_af", {31'h0, a_af}, 0);
        a_push(16'hA3);
        chk("f3_cnt", {29'h0, a_cnt}, 3);
        chk("f3_ae", {31'h0, a_ae}, 0);
        chk("f3_af", {31'h0, a_af}, 1);
        a_push(16'hA4);
        chk("f4_cnt", {29'h0, a_cnt}, 4);
        chk("f4_full", {31'h0, a_full}, 1);

        // Drain with one-cycle latency
        a_pop(16'hA1, "p1");
        a_pop(16'hA2, "p2");
        a_pop(16'hA3, "p3");
        a_pop(16'hA4, "p4");
        chk("p_empty", {31'h0, a_empty}, 1);
        tick();
        chk("idle_valid", {31'h0, a_valid}, 0);
        chk("idle_hold", {16'h0, a_rd}, 16'hA4);

        // Refill, then push+pop while full
        a_push(16'hA1); a_push(16'hA2); a_push(16'hA3); a_push(16'hA4);
        for (int i = 0; i < 3; i++) begin
            a_we = 1'b1; a_re = 1'b1; a_wd = 16'hB1 + 16'(i);
            tick();
            chk("sim_cnt", {29'h0, a_cnt}, 4);
            chk("sim_rd", {16'h0, a_rd}, 32'hA1 + i);
            chk("sim_ovf", {31'h0, a_ovf}, 0);
        end
        a_we = 1'b0; a_re = 1'b0;
        a_pop(16'hA4, "s4");
        a_pop(16'hB1, "sb1");
        a_pop(16'hB2, "sb2");
        a_pop(16'hB3, "sb3");
        chk("s_empty", {31'h0, a_empty}, 1);

        // Overflow: push while full is dropped and flag sticks
        a_push(16'hD1); a_push(16'hD2); a_push(16'hD3); a_push(16'hD4);
        a_push(16'hEE);
        chk("ovf_cnt", {29'h0, a_cnt}, 4);
        chk("ovf_set", {31'h0, a_ovf}, 1);
        tick();
        chk("ovf_sticky", {31'h0, a_ovf}, 1);
        a_pop(16'hD1, "d1");
        a_pop(16'hD2, "d2");
        a_pop(16'hD3, "d3");
        a_pop(16'hD4, "d4");

        // Underflow on empty
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
        chk("unf_set", {31'h0, a_unf}, 1);
        chk("unf_cnt", {29'h0, a_cnt}, 0);
        chk("unf_valid", {31'h0, a_valid}, 0);

        // Clear with a concurrent push: push dropped, no overflow
        a_push(16'h77);
        a_clr = 1'b1; a_we = 1'b1; a_wd = 16'h88;
        tick();
        a_clr = 1'b0; a_we = 1'b0;
        chk("clr_ovf", {31'h0, a_ovf}, 0);
        chk("clr_unf", {31'h0, a_unf}, 0);
        chk("clr_cnt", {29'h0, a_cnt}, 0);
        chk("clr_empty", {31'h0, a_empty}, 1);

        // Reset mid-stream at count 3, overriding a push
        a_push(16'hE1); a_push(16'hE2); a_push(16'hE3);
        chk("pre_rst_cnt", {29'h0, a_cnt}, 3);
        a_pop(16'hE1, "pre_rst_pop");
        a_push(16'hE4);
        a_rst_n = 1'b0; a_we = 1'b1; a_wd = 16'hE5;
        tick();
        a_rst_n = 1'b1; a_we = 1'b0;
        chk("mrst_cnt", {29'h0, a_cnt}, 0);
        chk("mrst_empty", {31'h0, a_empty}, 1);
        chk("mrst_rd", {16'h0, a_rd}, 0);
        chk("mrst_valid", {31'h0, a_valid}, 0);
        a_push(16'hC1);
        a_pop(16'hC1, "post_rst");

        // FWFT DEPTH=5: push/pop pairs walk the pointers through wrap
        for (int i = 0; i < 12; i++) begin
            b_we = 1'b1; b_wd = 16'h100 + 16'(i);
            tick();
            b_we = 1'b0;
            chk("fw_rd", {16'h0, b_rd}, 32'h100 + i);
            chk("fw_valid", {31'h0, b_valid}, 1);
            chk("fw_cnt1", {29'h0, b_cnt}, 1);
            b_re = 1'b1;
            tick();
            b_re = 1'b0;
            chk("fw_drop", {31'h0, b_valid}, 0);
            chk("fw_cnt0", {29'h0, b_cnt}, 0);
        end

        // FWFT fill to full across the wrap point, then drain in order
        for (int i = 0; i < 5; i++) begin
            b_we = 1'b1; b_wd = 16'h50 + 16'(i);
            tick();
        end
        b_we = 1'b0;
        chk("fw_full", {31'h0, b_full}, 1);
        chk("fw_cnt5", {29'h0, b_cnt}, 5);
        for (int i = 0; i < 5; i++) begin
            chk("fw_head", {16'h0, b_rd}, 32'h50 + i);
            b_re = 1'b1;
            tick();
            b_re = 1'b0;
        end
        chk("fw_empty", {31'h0, b_empty}, 1);

        // Push into empty with rd_en: push kept, underflow set
        b_we = 1'b1; b_re = 1'b1; b_wd = 16'h99;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        chk("fw_pu_cnt", {29'h0, b_cnt}, 1);
        chk("fw_pu_unf", {31'h0, b_unf}, 1);
        chk("fw_pu_rd", {16'h0, b_rd}, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
